// File: rtl/dm_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dm_master_pkg
// Brief   : Shared opcodes, state encodings and helpers for the data-memory
//           master (dm_master / dm_align).
// Revision: 1.0 - initial release
// ============================================================================
package dm_master_pkg;

   localparam logic [1:0] DM_WORD     = 2'b00;
   localparam logic [1:0] DM_HALFWORD = 2'b01;
   localparam logic [1:0] DM_BYTE     = 2'b10;

   localparam logic [1:0] DMA_IDLE = 2'd0;
   localparam logic [1:0] DMA_ADDR = 2'd1;
   localparam logic [1:0] DMA_WAIT = 2'd2;
   localparam logic [1:0] DMA_RESP = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = DMA_IDLE,
      ST_ADDR = DMA_ADDR,
      ST_WAIT = DMA_WAIT,
      ST_RESP = DMA_RESP
   } dma_state_e;

   // Unknown op encodings are treated as word accesses.
   function automatic logic misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
      case (op)
         DM_BYTE:     return 1'b0;
         DM_HALFWORD: return addr_lo[0];
         default:     return (addr_lo != 2'b00);
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_align.sv
`default_nettype none
// ============================================================================
// Module  : dm_align
// Brief   : Store lane enables / data replication and load extraction.
// Revision: 1.0 - initial release
// ============================================================================
module dm_align
   import dm_master_pkg::*;
(
   input  logic [1:0]  i_op,
   input  logic        i_unsigned,
   input  logic        i_we,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_byteen,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sign;

   assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      o_byteen  = 4'b0000;
      o_wdata   = i_wdata;
      o_ld_data = i_rdata;
      w_sign    = 1'b0;
      case (i_op)
         DM_BYTE: begin
            if (i_we) o_byteen = 4'b0001 << i_addr_lo;
            o_wdata   = {4{i_wdata[7:0]}};
            w_sign    = ~i_unsigned & w_byte[7];
            o_ld_data = {{24{w_sign}}, w_byte};
         end
         DM_HALFWORD: begin
            if (i_we) o_byteen = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata   = {2{i_wdata[15:0]}};
            w_sign    = ~i_unsigned & w_half[15];
            o_ld_data = {{16{w_sign}}, w_half};
         end
         default: begin
            if (i_we) o_byteen = 4'b1111;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dm_master.sv
`default_nettype none
// ============================================================================
// Module  : dm_master
// Brief   : M-stage load/store bus initiator with alignment checks, lane
//           steering, load extension and a bus timeout.
// Revision: 1.0 - initial release
// ============================================================================
module dm_master
   import dm_master_pkg::*;
#(
   parameter int DEPTH_WORDS = 3072,
   parameter int TIMEOUT     = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_op,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        stall,
   output logic        done,
   output logic [31:0] ld_data,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic        bus_err,
   output logic        m_data_req,
   input  logic        m_data_gnt,
   input  logic        m_data_rvalid,
   input  logic [31:0] m_data_rdata,
   output logic [31:0] m_data_addr,
   output logic [31:0] m_data_wdata,
   output logic [3:0]  m_data_byteen,
   output logic [31:0] m_inst_addr
);

   localparam int          c_CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [31:0] c_ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

   dma_state_e          r_state, w_next;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [31:0]         r_addr, r_wdata, r_pc, r_ld_data;
   logic [1:0]          r_op;
   logic                r_unsigned, r_we;
   logic                r_adel, r_ades, r_bus_err;
   logic                w_fault, w_timeout, w_busy;
   logic [31:0]         w_ld_ext;

   assign w_fault   = misaligned(req_op, req_addr[1:0]) || (req_addr >= c_ADDR_LIMIT);
   assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT - 1));
   assign w_busy    = (r_state == ST_ADDR) || (r_state == ST_WAIT);

   dm_align u_align (
      .i_op       (r_op),
      .i_unsigned (r_unsigned),
      .i_we       (r_we),
      .i_addr_lo  (r_addr[1:0]),
      .i_wdata    (r_wdata),
      .i_rdata    (m_data_rdata),
      .o_byteen   (m_data_byteen),
      .o_wdata    (m_data_wdata),
      .o_ld_data  (w_ld_ext)
   );

   always_comb begin
      w_next     = r_state;
      stall      = 1'b0;
      m_data_req = 1'b0;
      done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Gated by reset so every output reads 0 while reset is held.
            stall = req_valid & reset;
            if (req_valid) w_next = w_fault ? ST_RESP : ST_ADDR;
         end
         ST_ADDR: begin
            stall      = 1'b1;
            m_data_req = 1'b1;
            if (w_timeout)       w_next = ST_RESP;
            else if (m_data_gnt) w_next = ST_WAIT;
         end
         ST_WAIT: begin
            stall = 1'b1;
            if (m_data_rvalid || w_timeout) w_next = ST_RESP;
         end
         ST_RESP: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_pc       <= '0;
         r_op       <= DM_WORD;
         r_unsigned <= 1'b0;
         r_we       <= 1'b0;
         r_ld_data  <= '0;
         r_adel     <= 1'b0;
         r_ades     <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_adel    <= 1'b0;
         r_ades    <= 1'b0;
         r_bus_err <= 1'b0;
         // One budget spans ADDR and WAIT together.
         if (w_busy && (w_next != ST_RESP)) r_cnt <= r_cnt + 1'b1;
         else                               r_cnt <= '0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid && w_fault) begin
                  r_adel <= ~req_we;
                  r_ades <= req_we;
               end else if (req_valid) begin
                  r_addr     <= req_addr;
                  r_op       <= req_op;
                  r_unsigned <= req_unsigned;
                  r_we       <= req_we;
                  r_wdata    <= req_wdata;
                  r_pc       <= req_pc;
               end
            end
            ST_ADDR: if (w_timeout) r_bus_err <= 1'b1;
            ST_WAIT: begin
               if (m_data_rvalid)  r_ld_data <= w_ld_ext;
               else if (w_timeout) r_bus_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ld_data     = r_ld_data;
   assign exc_adel    = r_adel;
   assign exc_ades    = r_ades;
   assign bus_err     = r_bus_err;
   assign m_data_addr = {r_addr[31:2], 2'b00};
   assign m_inst_addr = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_dm_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_dm_master
// Brief   : Self-checking bench for dm_master: directed table, randomized
//           accesses against a lane-level reference model, corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dm_master;
   import dm_master_pkg::*;

   localparam int DEPTH_WORDS = 3072;
   localparam int TIMEOUT     = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_op = DM_WORD;
   logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
   logic        stall, done, exc_adel, exc_ades, bus_err, m_data_req;
   logic [31:0] ld_data, m_data_addr, m_data_wdata, m_inst_addr;
   logic [3:0]  m_data_byteen;
   logic        m_data_gnt = 1'b0, m_data_rvalid = 1'b0;
   logic [31:0] m_data_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dm_master #(.DEPTH_WORDS(DEPTH_WORDS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_pc(req_pc), .stall(stall), .done(done), .ld_data(ld_data),
      .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err),
      .m_data_req(m_data_req), .m_data_gnt(m_data_gnt),
      .m_data_rvalid(m_data_rvalid), .m_data_rdata(m_data_rdata),
      .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
      .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr)
   );

   typedef struct {
      logic        we;
      logic [1:0]  op;
      logic        uns;
      logic [31:0] addr, wdata, rdata, pc;
      logic        fault;
      logic [3:0]  byteen;
      logic [31:0] bwdata, baddr, ld;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic we, input logic [1:0] op, input logic uns,
                                input logic [31:0] addr, wdata, rdata, input logic fault,
                                input logic [3:0] be, input logic [31:0] bwd, baddr, ld);
      vec_t v;
      v.we = we; v.op = op; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.pc = 32'h0040_0000 + addr; v.fault = fault;
      v.byteen = be; v.bwdata = bwd; v.baddr = baddr; v.ld = ld;
      return v;
   endfunction

   // Reference: an access covers `size` consecutive bytes starting at addr%4.
   function automatic vec_t ref_model(input logic we, input logic [1:0] op, input logic uns,
                                      input logic [31:0] addr, wdata, rdata, pc);
      vec_t   v;
      int     size, off;
      longint val;
      size = (op == DM_BYTE) ? 1 : (op == DM_HALFWORD) ? 2 : 4;
      off  = int'(addr % 4);
      v.we = we; v.op = op; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.pc = pc;
      v.fault  = ((addr % size) != 0) || (addr >= 4 * DEPTH_WORDS);
      v.baddr  = addr - (addr % 4);
      v.byteen = '0;
      for (int i = 0; i < 4; i++) begin
         if (we && i >= off && i < off + size) v.byteen[i] = 1'b1;
         v.bwdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
      val = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
      if (!uns && size < 4 && val >= (longint'(1) << (8 * size - 1)))
         val = val - (longint'(1) << (8 * size));
      v.ld = val[31:0];
      return v;
   endfunction

   // gd: extra cycles before gnt; rdl: extra WAIT cycles before rvalid.
   task automatic run_access(input vec_t v, input int gd, input int rdl, input string tag);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = v.we; req_op = v.op; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata; req_pc = v.pc;
      @(negedge clk);
      chk({tag, "_stall_idle"}, stall, 1);
      chk({tag, "_req_idle"}, m_data_req, 0);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
      if (v.fault) begin
         @(negedge clk);
         chk({tag, "_done"}, done, 1);
         chk({tag, "_adel"}, exc_adel, !v.we);
         chk({tag, "_ades"}, exc_ades, v.we);
         chk({tag, "_buserr"}, bus_err, 0);
         chk({tag, "_stall"}, stall, 0);
         chk({tag, "_req_fault"}, m_data_req, 0);
      end else begin
         for (int k = 0; k <= gd; k++) begin
            m_data_gnt = (k == gd); m_data_rvalid = 1'($urandom_range(0, 1));
            m_data_rdata = $urandom;
            @(negedge clk);
            chk({tag, "_req_addr"}, m_data_req, 1);
            chk({tag, "_stall_addr"}, stall, 1);
            chk({tag, "_done_addr"}, done, 0);
            if (k == 0) begin
               chk({tag, "_baddr"}, m_data_addr, v.baddr);
               chk({tag, "_byteen"}, m_data_byteen, v.byteen);
               chk({tag, "_pc"}, m_inst_addr, v.pc);
               if (v.we) chk({tag, "_wdata"}, m_data_wdata, v.bwdata);
            end
            @(posedge clk); #1;
         end
         m_data_gnt = 1'b0;
         for (int k = 0; k <= rdl; k++) begin
            m_data_rvalid = (k == rdl);
            m_data_rdata  = (k == rdl) ? v.rdata : $urandom;
            @(negedge clk);
            chk({tag, "_req_wait"}, m_data_req, 0);
            chk({tag, "_stall_wait"}, stall, 1);
            chk({tag, "_done_wait"}, done, 0);
            @(posedge clk); #1;
         end
         m_data_rvalid = 1'b0; m_data_rdata = $urandom;
         @(negedge clk);
         chk({tag, "_done"}, done, 1);
         chk({tag, "_stall"}, stall, 0);
         chk({tag, "_flags"}, {exc_adel, exc_ades, bus_err}, 0);
         if (!v.we) chk({tag, "_ld"}, ld_data, v.ld);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_flags_clr"}, {exc_adel, exc_ades, bus_err}, 0);
      if (!v.we && !v.fault) chk({tag, "_ld_hold"}, ld_data, v.ld);
   endtask

   vec_t tbl[12];
   vec_t rv;

   initial begin
      tbl[0]  = mkv(1, DM_WORD,     0, 32'h100,  32'h12345678, 32'h0,        0, 4'b1111, 32'h12345678, 32'h100,  32'h0);
      tbl[1]  = mkv(1, DM_HALFWORD, 0, 32'h102,  32'h0000BEEF, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'h100,  32'h0);
      tbl[2]  = mkv(0, DM_BYTE,     0, 32'h203,  32'h0,        32'h80000000, 0, 4'b0000, 32'h0,        32'h200,  32'hFFFFFF80);
      tbl[3]  = mkv(0, DM_BYTE,     1, 32'h203,  32'h0,        32'h80000000, 0, 4'b0000, 32'h0,        32'h200,  32'h00000080);
      tbl[4]  = mkv(0, DM_WORD,     0, 32'h202,  32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h200,  32'h0);
      tbl[5]  = mkv(1, DM_BYTE,     0, 32'h301,  32'h123456A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h300,  32'h0);
      tbl[6]  = mkv(0, DM_HALFWORD, 0, 32'h402,  32'h0,        32'h80017FFF, 0, 4'b0000, 32'h0,        32'h400,  32'hFFFF8001);
      tbl[7]  = mkv(0, DM_HALFWORD, 1, 32'h400,  32'h0,        32'h1234ABCD, 0, 4'b0000, 32'h0,        32'h400,  32'h0000ABCD);
      tbl[8]  = mkv(1, DM_WORD,     0, 32'h3000, 32'hDEADBEEF, 32'h0,        1, 4'b0000, 32'h0,        32'h3000, 32'h0);
      tbl[9]  = mkv(0, DM_WORD,     0, 32'h2FFC, 32'h0,        32'hCAFEF00D, 0, 4'b0000, 32'h0,        32'h2FFC, 32'hCAFEF00D);
      tbl[10] = mkv(1, DM_HALFWORD, 0, 32'h101,  32'h00001234, 32'h0,        1, 4'b0000, 32'h0,        32'h100,  32'h0);
      tbl[11] = mkv(0, DM_BYTE,     0, 32'h001,  32'h0,        32'h00007F00, 0, 4'b0000, 32'h0,        32'h0,    32'h0000007F);

      // Reset state
      #1;
      chk("rst_stall", stall, 0);       chk("rst_done", done, 0);
      chk("rst_req", m_data_req, 0);    chk("rst_addr", m_data_addr, 0);
      chk("rst_wdata", m_data_wdata, 0); chk("rst_byteen", m_data_byteen, 0);
      chk("rst_pc", m_inst_addr, 0);    chk("rst_ld", ld_data, 0);
      chk("rst_flags", {exc_adel, exc_ades, bus_err}, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 12; i++) run_access(tbl[i], 0, 0, $sformatf("tbl%0d", i));

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  op;
         logic [31:0] a;
         op = (i % 3 == 0) ? DM_WORD : (i % 3 == 1) ? DM_HALFWORD : DM_BYTE;
         a  = 32'($urandom_range(0, 4 * DEPTH_WORDS + 31));
         if ($urandom_range(0, 3) != 0) begin
            if (op == DM_WORD) a[1:0] = 2'b00;
            else if (op == DM_HALFWORD) a[0] = 1'b0;
         end
         rv = ref_model(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), a,
                        $urandom, $urandom, $urandom);
         run_access(rv, $urandom_range(0, 4), $urandom_range(0, 4), $sformatf("rnd%0d", i));
      end

      // Grant withheld: bus_err after TIMEOUT cycles in ADDR
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_op = DM_WORD; req_addr = 32'h80; req_pc = 32'h1000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k < TIMEOUT; k++) begin
         @(negedge clk);
         chk("to_req", m_data_req, 1);
         chk("to_done_early", done, 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("to_done", done, 1);  chk("to_buserr", bus_err, 1);
      chk("to_stall", stall, 0); chk("to_exc", {exc_adel, exc_ades}, 0);
      chk("to_req_resp", m_data_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_idle_done", done, 0); chk("to_idle_buserr", bus_err, 0);
      chk("to_idle_req", m_data_req, 0); chk("to_idle_stall", stall, 0);

      // Request offered during RESP is only taken in the following IDLE
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_op = DM_WORD; req_addr = 32'h40;
      req_wdata = 32'h11111111; req_pc = 32'h2000;
      @(posedge clk); #1;
      req_valid = 1'b0; m_data_gnt = 1'b1;
      @(posedge clk); #1;
      m_data_gnt = 1'b0; m_data_rvalid = 1'b1;
      @(posedge clk); #1;
      m_data_rvalid = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_op = DM_WORD; req_addr = 32'h44; req_pc = 32'h2004;
      @(negedge clk);
      chk("ovl_done", done, 1); chk("ovl_stall_resp", stall, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ovl_idle_req", m_data_req, 0); chk("ovl_idle_stall", stall, 1);
      chk("ovl_idle_done", done, 0);
      @(posedge clk); #1;
      req_valid = 1'b0; m_data_gnt = 1'b1;
      @(negedge clk);
      chk("ovl_addr_req", m_data_req, 1); chk("ovl_addr", m_data_addr, 32'h44);
      chk("ovl_byteen", m_data_byteen, 4'b0000);
      @(posedge clk); #1;
      m_data_gnt = 1'b0; m_data_rvalid = 1'b1; m_data_rdata = 32'h55667788;
      @(posedge clk); #1;
      m_data_rvalid = 1'b0;
      @(negedge clk);
      chk("ovl2_done", done, 1); chk("ovl2_ld", ld_data, 32'h55667788);

      // Reset asserted while in WAIT aborts without a done pulse
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_op = DM_WORD; req_addr = 32'h500; req_pc = 32'h3000;
      @(posedge clk); #1;
      req_valid = 1'b0; m_data_gnt = 1'b1;
      @(posedge clk); #1;
      m_data_gnt = 1'b0;
      @(negedge clk);
      chk("rw_wait_req", m_data_req, 0); chk("rw_wait_stall", stall, 1);
      #2;
      reset = 1'b0; m_data_rvalid = 1'b1; m_data_rdata = 32'hA5A5A5A5;
      #1;
      chk("rw_req", m_data_req, 0); chk("rw_stall", stall, 0); chk("rw_done", done, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rw_hold_done", done, 0);
      end
      @(posedge clk); #1;
      reset = 1'b1; m_data_rvalid = 1'b0;
      run_access(ref_model(1'b0, DM_WORD, 1'b0, 32'h504, 32'h0, 32'h0BADF00D, 32'h3004),
                 0, 0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
